// File: rtl/mc_control_fsm_if.sv
// Control bus between the instruction register / multicycle datapath and
// the main controller. The controller drives the master side.
interface mc_control_fsm_if #(
    parameter int unsigned ALUOP_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               memread;
    logic               memwrite;
    logic               iord;
    logic               irwrite;
    logic               pcwrite;
    logic               branch;
    logic               ne;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
    logic               fpu_start;
    logic [3:0]         fpu_control;
    logic               fp_regwrite;
    logic               illegal;

    modport master (
        input  op, funct, mem_ready,
        output memread, memwrite, iord, irwrite, pcwrite, branch, ne,
               alusrca, alusrcb, pcsrc, regdst, memtoreg, regwrite, aluop,
               fpu_start, fpu_control, fp_regwrite, illegal
    );

    modport slave (
        output op, funct, mem_ready,
        input  memread, memwrite, iord, irwrite, pcwrite, branch, ne,
               alusrca, alusrcb, pcsrc, regdst, memtoreg, regwrite, aluop,
               fpu_start, fpu_control, fp_regwrite, illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, stalling on mem_ready and waiting FP_LATENCY cycles
// for the FPU.
module mc_control_fsm #(
    parameter int unsigned FP_LATENCY = 4,
    parameter int unsigned ALUOP_W    = 4
) (
    input logic             clk,
    input logic             reset,
    mc_control_fsm_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_FP    = 6'b010001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = '1;

    localparam logic [3:0] FP_CNT_INIT = 4'(FP_LATENCY - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
        IEXEC, IWB, BRANCH, JUMP, FPEXEC, FPWB
    } state_t;

    state_t     state;
    state_t     decode_target;
    logic       decode_illegal;
    logic [3:0] fp_cnt;
    logic [3:0] fpu_ctrl_q;
    logic       bne_q;

    logic                memread, memwrite, iord, irwrite, pcwrite, branch;
    logic                alusrca, regdst, memtoreg, regwrite;
    logic                fpu_start, fp_regwrite, illegal;
    logic [1:0]          alusrcb, pcsrc;
    logic [ALUOP_W-1:0]  aluop;

    // Instruction decode: successor of DECODE and the undecoded-instruction flag.
    always_comb begin
        decode_target  = FETCH;
        decode_illegal = 1'b0;
        case (bus.op)
            OP_LW, OP_SW:      decode_target = MEMADR;
            OP_RTYPE:          decode_target = EXEC;
            OP_ADDI, OP_ADDIU: decode_target = IEXEC;
            OP_BEQ, OP_BNE:    decode_target = BRANCH;
            OP_J:              decode_target = JUMP;
            OP_FP: begin
                if (bus.funct[5:2] == 4'b0000) decode_target  = FPEXEC;
                else                           decode_illegal = 1'b1;
            end
            default:           decode_illegal = 1'b1;
        endcase
    end

    // State register plus FP latency counter and the values latched in DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            fp_cnt     <= '0;
            fpu_ctrl_q <= '0;
            bne_q      <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    state <= decode_target;
                    bne_q <= (bus.op == OP_BNE);
                    if (decode_target == FPEXEC) begin
                        fp_cnt     <= FP_CNT_INIT;
                        fpu_ctrl_q <= {bus.funct[1:0], 2'b01};
                    end
                end
                MEMADR: state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (bus.mem_ready) state <= MEMWB;
                MEMWR:  if (bus.mem_ready) state <= FETCH;
                EXEC:   state <= RWB;
                IEXEC:  state <= IWB;
                FPEXEC: begin
                    if (fp_cnt == '0) state  <= FPWB;
                    else              fp_cnt <= fp_cnt - 4'd1;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Moore output decode; everything forced low while reset is asserted.
    // irwrite/pcwrite in FETCH are qualified by mem_ready so the IR and PC
    // load on the same edge that completes the fetch.
    always_comb begin
        memread = 1'b0; memwrite = 1'b0; iord = 1'b0; irwrite = 1'b0;
        pcwrite = 1'b0; branch = 1'b0; alusrca = 1'b0; regdst = 1'b0;
        memtoreg = 1'b0; regwrite = 1'b0; fpu_start = 1'b0;
        fp_regwrite = 1'b0; illegal = 1'b0;
        alusrcb = 2'b00; pcsrc = 2'b00; aluop = ALU_ADD;
        if (reset) begin
            case (state)
                FETCH: begin
                    memread = 1'b1; alusrcb = 2'b01;
                    irwrite = bus.mem_ready; pcwrite = bus.mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11; illegal = decode_illegal;
                end
                MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
                MEMRD:  begin iord = 1'b1; memread = 1'b1; end
                MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
                MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
                EXEC:   begin alusrca = 1'b1; aluop = ALU_RTYPE; end
                RWB:    begin regwrite = 1'b1; regdst = 1'b1; end
                IEXEC:  begin alusrca = 1'b1; alusrcb = 2'b10; end
                IWB:    regwrite = 1'b1;
                BRANCH: begin
                    alusrca = 1'b1; aluop = ALU_SUB; pcsrc = 2'b01; branch = 1'b1;
                end
                JUMP:   begin pcwrite = 1'b1; pcsrc = 2'b10; end
                FPEXEC: fpu_start = (fp_cnt == FP_CNT_INIT);
                FPWB:   fp_regwrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.memread     = memread;
    assign bus.memwrite    = memwrite;
    assign bus.iord        = iord;
    assign bus.irwrite     = irwrite;
    assign bus.pcwrite     = pcwrite;
    assign bus.branch      = branch;
    assign bus.ne          = branch & bne_q;
    assign bus.alusrca     = alusrca;
    assign bus.alusrcb     = alusrcb;
    assign bus.pcsrc       = pcsrc;
    assign bus.regdst      = regdst;
    assign bus.memtoreg    = memtoreg;
    assign bus.regwrite    = regwrite;
    assign bus.aluop       = aluop;
    assign bus.fpu_start   = fpu_start;
    assign bus.fpu_control = fpu_ctrl_q;
    assign bus.fp_regwrite = fp_regwrite;
    assign bus.illegal     = illegal;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-instruction cycle script built from the
// instruction set rules predicts every control output each cycle.
module tb_mc_control_fsm;
    localparam int unsigned LAT = 4;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4,
                   K_J = 5, K_FP = 6, K_ILL = 7;

    typedef struct packed {
        logic       memread, memwrite, iord, irwrite, pcwrite, branch, ne, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       regdst, memtoreg, regwrite;
        logic [3:0] aluop;
        logic       fpu_start, fp_regwrite, illegal;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.ALUOP_W(4)) bus ();
    mc_control_fsm #(.FP_LATENCY(LAT), .ALUOP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ctl_t       exp_q[$], act_q[$];
    logic       mr_q[$];
    logic [5:0] op_q[$], fn_q[$];
    logic [3:0] fpc_q[$], fpa_q[$];
    logic [3:0] fpc_model;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b001000, 6'b001001: return K_I;
            6'b000100, 6'b000101: return K_BR;
            6'b000010: return K_J;
            6'b010001: return (f < 6'd4) ? K_FP : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.memread = bus.memread;   c.memwrite = bus.memwrite; c.iord = bus.iord;
        c.irwrite = bus.irwrite;   c.pcwrite = bus.pcwrite;   c.branch = bus.branch;
        c.ne = bus.ne;             c.alusrca = bus.alusrca;   c.alusrcb = bus.alusrcb;
        c.pcsrc = bus.pcsrc;       c.regdst = bus.regdst;     c.memtoreg = bus.memtoreg;
        c.regwrite = bus.regwrite; c.aluop = bus.aluop;       c.fpu_start = bus.fpu_start;
        c.fp_regwrite = bus.fp_regwrite; c.illegal = bus.illegal;
        return c;
    endfunction

    task automatic clear_q();
        exp_q.delete(); act_q.delete(); mr_q.delete(); op_q.delete();
        fn_q.delete(); fpc_q.delete(); fpa_q.delete();
    endtask

    task automatic push(input logic mr, input logic [5:0] o, input logic [5:0] f, input ctl_t c);
        mr_q.push_back(mr); op_q.push_back(o); fn_q.push_back(f);
        exp_q.push_back(c); fpc_q.push_back(fpc_model);
    endtask

    // Expected cycle-by-cycle script of one instruction: fs fetch stalls, ms memory stalls.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input int fs, input int ms);
        ctl_t c;
        int   k = kind_of(o, f);
        for (int i = 0; i < fs; i++) begin
            c = '0; c.memread = 1'b1; c.alusrcb = 2'b01;
            push(1'b0, 6'($urandom), 6'($urandom), c);
        end
        c = '0; c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        push(1'b1, o, f, c);
        c = '0; c.alusrcb = 2'b11; c.illegal = (k == K_ILL);
        push(1'($urandom), o, f, c);
        if (k == K_FP) fpc_model = {f[1:0], 2'b01};
        case (k)
            K_LW, K_SW: begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
                push(1'($urandom), o, f, c);
                for (int i = 0; i <= ms; i++) begin
                    c = '0; c.iord = 1'b1;
                    if (k == K_LW) c.memread = 1'b1; else c.memwrite = 1'b1;
                    push(i == ms, o, f, c);
                end
                if (k == K_LW) begin
                    c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1;
                    push(1'($urandom), o, f, c);
                end
            end
            K_R: begin
                c = '0; c.alusrca = 1'b1; c.aluop = 4'b1111; push(1'($urandom), o, f, c);
                c = '0; c.regwrite = 1'b1; c.regdst = 1'b1;  push(1'($urandom), o, f, c);
            end
            K_I: begin
                c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; push(1'($urandom), o, f, c);
                c = '0; c.regwrite = 1'b1;                   push(1'($urandom), o, f, c);
            end
            K_BR: begin
                c = '0; c.alusrca = 1'b1; c.aluop = 4'b0001; c.pcsrc = 2'b01;
                c.branch = 1'b1; c.ne = (o == 6'b000101);
                push(1'($urandom), o, f, c);
            end
            K_J: begin
                c = '0; c.pcwrite = 1'b1; c.pcsrc = 2'b10; push(1'($urandom), o, f, c);
            end
            K_FP: begin
                for (int i = 0; i < int'(LAT); i++) begin
                    c = '0; c.fpu_start = (i == 0); push(1'($urandom), o, f, c);
                end
                c = '0; c.fp_regwrite = 1'b1; push(1'($urandom), o, f, c);
            end
            default: ;
        endcase
    endtask

    // Applies n scripted cycles (all when n<0); entered and left just after a rising edge.
    task automatic play(input int n);
        int lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            bus.mem_ready = mr_q[i]; bus.op = op_q[i]; bus.funct = fn_q[i];
            @(negedge clk);
            act_q.push_back(observed());
            fpa_q.push_back(bus.fpu_control);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.mem_ready = 1'b1; bus.op = 6'b100011; bus.funct = '0;
        fpc_model = '0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (observed() !== ctl_t'(0) || bus.fpu_control !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_outputs got=%h/%h exp=0/0", observed(), bus.fpu_control);
            end
        end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_directed();
        clear_q();
        build(6'b100011, 6'($urandom), 0, 0);   // LW, no stalls
        build(6'b101011, 6'($urandom), 0, 3);   // SW, 3 stall cycles in MEMWR
        build(6'b010001, 6'b000001, 0, 0);      // FP sub
        build(6'b000101, 6'($urandom), 0, 0);   // BNE
        build(6'b111111, 6'($urandom), 0, 0);   // undefined op
        build(6'b010001, 6'b000111, 0, 0);      // FP with funct > 3
        build(6'b000100, 6'($urandom), 2, 0);   // BEQ with fetch stalls
        build(6'b000010, 6'($urandom), 1, 0);   // J
        build(6'b000000, 6'($urandom), 0, 0);   // R-type
        build(6'b001001, 6'($urandom), 0, 0);   // ADDIU
        build(6'b100011, 6'($urandom), 1, 2);   // LW with both stalls
        play(-1);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL dir_ctl cyc=%0d op=%b got=%h exp=%h", i, op_q[i], act_q[i], exp_q[i]);
            end
            vectors++;
            if (fpa_q[i] !== fpc_q[i]) begin
                miscompares++;
                $display("FAIL dir_fpu_control cyc=%0d got=%b exp=%b", i, fpa_q[i], fpc_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        clear_q();
        for (int n = 0; n < 150; n++) begin
            f = 6'($urandom);
            case ($urandom_range(0, 9))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b001000;
                4: o = 6'b001001;
                5: o = 6'b000100;
                6: o = 6'b000101;
                7: o = 6'b000010;
                8: begin
                    o = 6'b010001;
                    if ($urandom_range(0, 3) != 0) f = 6'($urandom_range(0, 3));
                end
                default: begin
                    o = 6'($urandom);
                    while (kind_of(o, f) != K_ILL) o = 6'($urandom);
                end
            endcase
            build(o, f, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        play(-1);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rnd_ctl cyc=%0d op=%b got=%h exp=%h", i, op_q[i], act_q[i], exp_q[i]);
            end
            vectors++;
            if (fpa_q[i] !== fpc_q[i]) begin
                miscompares++;
                $display("FAIL rnd_fpu_control cyc=%0d got=%b exp=%b", i, fpa_q[i], fpc_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fp();
        clear_q();
        build(6'b010001, 6'b000010, 0, 0);
        play(3);                                // FETCH, DECODE, first FPEXEC cycle
        for (int i = 0; i < act_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i] || fpa_q[i] !== fpc_q[i]) begin
                miscompares++;
                $display("FAIL midfp_pre cyc=%0d got=%h/%b exp=%h/%b",
                         i, act_q[i], fpa_q[i], exp_q[i], fpc_q[i]);
            end
        end
        bus.mem_ready = 1'b1;
        #2;
        vectors++;
        if (bus.fpu_control !== 4'b1001) begin
            miscompares++;
            $display("FAIL midfp_held got=%b exp=1001", bus.fpu_control);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (observed() !== ctl_t'(0) || bus.fpu_control !== 4'd0 || dut.fp_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL midfp_async got=%h/%b cnt=%0d exp=0/0 cnt=0",
                     observed(), bus.fpu_control, dut.fp_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; fpc_model = '0;
        clear_q();
        build(6'b000010, 6'($urandom), 0, 0);
        build(6'b010001, 6'b000011, 1, 0);
        play(-1);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i] || fpa_q[i] !== fpc_q[i]) begin
                miscompares++;
                $display("FAIL midfp_restart cyc=%0d got=%h/%b exp=%h/%b",
                         i, act_q[i], fpa_q[i], exp_q[i], fpc_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_fp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
